// File: rtl/audio_pkg.sv
// Shared types and constants for the WM8731 audio path.
// FSM encoding, channel ids and default sample width.
package audio_pkg;

  localparam int DEF_DATA_WIDTH = 16;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ALIGN,
    DELAY,
    SHIFT,
    WAIT
  } rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an async level plus
// a one-clk pulse on its rising (or falling) edge.
module sync_edge_det
  import audio_pkg::*;
#(
  parameter int STAGES  = 2,
  parameter bit RISING  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic              q;

  assign q = chain[STAGES-1];

  // shift the async level in; remember last synced value
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= q;
    end
  end

  assign pulse = RISING ? (q & ~prev) : (~q & prev);

endmodule

// File: rtl/audio_adc_i2s_rx.sv
// WM8731 ADC I2S receiver: oversampled serial in,
// one {left,right} word per LRC frame on valid/ready out.
module audio_adc_i2s_rx
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bclk,
  input  logic                    adclrc,
  input  logic                    adcdat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    overflow,
  output logic                    frame_err
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);

  logic                   bit_tick;
  logic [SYNC_STAGES-1:0] lrc_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   lrc_s;
  logic                   dat_s;
  logic                   lrc_prev;
  logic                   lrc_edge;

  rx_state_t              state, state_n;
  logic [CW-1:0]          bit_cnt, bit_cnt_n;
  logic                   ch, ch_n;
  logic [DATA_WIDTH-1:0]  shreg, shreg_n;
  logic [DATA_WIDTH-1:0]  left_q, left_n;
  logic                   have_left, have_left_n;

  logic                   ch_done;
  logic [DATA_WIDTH-1:0]  ch_word;
  logic                   err;
  logic                   pair_fire;

  logic                   pair_v;
  logic [2*DATA_WIDTH-1:0] pair_q;

  sync_edge_det #(
    .STAGES (SYNC_STAGES),
    .RISING (1'b1)
  ) u_bclk (
    .clk   (clk),
    .rst   (rst),
    .d     (bclk),
    .pulse (bit_tick)
  );

  // lrc/dat chains match the bclk chain depth
  always_ff @(posedge clk) begin
    if (rst) begin
      lrc_sync <= '0;
      dat_sync <= '0;
    end else begin
      lrc_sync <= {lrc_sync[SYNC_STAGES-2:0], adclrc};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], adcdat};
    end
  end

  assign lrc_s    = lrc_sync[SYNC_STAGES-1];
  assign dat_s    = dat_sync[SYNC_STAGES-1];
  assign lrc_edge = lrc_s ^ lrc_prev;

  // next-state, shift and channel-store decisions
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    ch_n        = ch;
    shreg_n     = shreg;
    left_n      = left_q;
    have_left_n = have_left;
    ch_done     = 1'b0;
    ch_word     = '0;
    err         = 1'b0;
    pair_fire   = 1'b0;
    if (bit_tick) begin
      unique case (state)
        ALIGN: begin
          if (lrc_edge && lrc_s == CH_LEFT) begin
            state_n     = DELAY;
            ch_n        = CH_LEFT;
            have_left_n = 1'b0;
          end
        end
        // the LRC-edge bit was the old LSB; this one is the MSB
        DELAY: begin
          if (lrc_edge) begin
            ch_n = lrc_s;
          end else begin
            shreg_n   = {{(DATA_WIDTH-1){1'b0}}, dat_s};
            bit_cnt_n = CW'(1);
            state_n   = SHIFT;
          end
        end
        SHIFT: begin
          if (lrc_edge) begin
            ch_done = 1'b1;
            ch_word = shreg << (FULL - bit_cnt);
            err     = 1'b1;
            ch_n    = lrc_s;
            state_n = DELAY;
          end else begin
            shreg_n   = {shreg[DATA_WIDTH-2:0], dat_s};
            bit_cnt_n = bit_cnt + CW'(1);
            if (bit_cnt == LAST) begin
              ch_done = 1'b1;
              ch_word = {shreg[DATA_WIDTH-2:0], dat_s};
              state_n = WAIT;
            end
          end
        end
        WAIT: begin
          if (lrc_edge) begin
            ch_n    = lrc_s;
            state_n = DELAY;
          end
        end
        default: state_n = ALIGN;
      endcase
    end
    if (ch_done) begin
      if (ch == CH_LEFT) begin
        left_n      = ch_word;
        have_left_n = 1'b1;
      end else if (have_left) begin
        pair_fire   = 1'b1;
        have_left_n = 1'b0;
      end
    end
  end

  // FSM and serial datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ALIGN;
      bit_cnt   <= '0;
      ch        <= CH_LEFT;
      shreg     <= '0;
      left_q    <= '0;
      have_left <= 1'b0;
      lrc_prev  <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      ch        <= ch_n;
      shreg     <= shreg_n;
      left_q    <= left_n;
      have_left <= have_left_n;
      if (bit_tick) lrc_prev <= lrc_s;
    end
  end

  // stage the stereo word, then hand it to the output port
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_v    <= 1'b0;
      pair_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      pair_v    <= pair_fire;
      frame_err <= err;
      overflow  <= 1'b0;
      if (pair_fire) pair_q <= {left_q, ch_word};
      if (pair_v) begin
        if (!out_valid || out_ready) begin
          out_data  <= pair_q;
          out_valid <= 1'b1;
        end else begin
          overflow  <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
